exec_unit: RTL and testbench
============================

# exec_unit

Implements the `exec` module: per-wavefront storage for the scalar architectural state EXEC (64-bit), VCC (64-bit), M0 (32-bit) and SCC (1-bit). It sits between fetch, the SALU, the SIMD/SIMF vector ALUs, the LSU and issue. It services registered reads for every functional unit and accepts writes from fetch (init), the SALU, and the VALUs. It also echoes completed writes to issue so dependencies can clear.

## Interface
- NUMWF, 40, number of wavefront entries (valid wfids 0..39).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_init_wf_en / fetch_init_wf_id / fetch_init_value  in  1/6/64  wavefront init: EXEC := value.
- salu_wr_exec_en, salu_wr_vcc_en, salu_wr_m0_en, salu_wr_scc_en  in  1 each  SALU write enables.
- salu_wr_wfid  in  6  target wavefront for all SALU writes.
- salu_wr_exec_value / salu_wr_vcc_value / salu_wr_m0_value / salu_wr_scc_value  in  64/64/32/1  SALU write data.
- salu_rd_en / salu_rd_wfid  in  1/6  SALU read request.
- simd{0..3}_rd_en / simd{0..3}_rd_wfid  in  1/6  SIMD read requests (shared SIMD read port).
- simf{0..3}_rd_en / simf{0..3}_rd_wfid  in  1/6  SIMF read requests (shared SIMF read port).
- simd{0..3}_vcc_wr_en / _wr_wfid / _value  in  1/6/64  SIMD VCC writes.
- simf{0..3}_vcc_wr_en / _wr_wfid / _value  in  1/6/64  SIMF VCC writes.
- rfa_select_fu  in  16  one-hot writeback grant: bit0..3 = simd0..3, bit4..7 = simf0..3; bits 8..15 are ignored.
- lsu_rd_wfid  in  6  LSU read wfid (no enable).
- lsu_exec_value / lsu_rd_m0_value  out  64/32.
- salu_rd_exec_value / salu_rd_vcc_value / salu_rd_m0_value / salu_rd_scc_value  out  64/64/32/1.
- simd_rd_exec_value / simd_rd_vcc_value / simd_rd_m0_value / simd_rd_scc_value  out  64/64/32/1.
- simf_rd_exec_value / simf_rd_vcc_value / simf_rd_m0_value / simf_rd_scc_value  out  64/64/32/1.
- issue_salu_wr_exec_en, issue_salu_wr_vcc_en, issue_salu_wr_m0_en, issue_salu_wr_scc_en  out  1  write-done notifications.
- issue_salu_wr_vcc_wfid  out  6  wfid of the notified SALU write.
- issue_valu_wr_vcc_en / issue_valu_wr_vcc_wfid  out  1/6  VALU VCC write-done notification.

## Operation
- Storage: NUMWF entries each of EXEC, VCC, M0, SCC. Writes to wfid ≥ NUMWF are dropped; reads of such ids return 0.
- Fetch init: sets EXEC := fetch_init_value and clears VCC, M0, SCC of that wfid.
- SALU write: each enabled field is written independently to salu_wr_wfid.
- VALU VCC write: unit k is accepted only when its `*_vcc_wr_en` is high and rfa_select_fu bit k is high. If several qualify, the lowest bit index wins.
- Write priority on the same wfid and field in one cycle: fetch init > SALU > VALU.
- Read ports for SALU, SIMD, SIMF and LSU each hold a captured wfid register.
  - SALU captures on salu_rd_en.
  - SIMD captures the wfid of the lowest-index asserted simdN_rd_en; SIMF does the same with simfN_rd_en.
  - LSU captures lsu_rd_wfid every cycle.
  - With no enable asserted, the captured wfid is held.
- Outputs continuously show the current stored contents of the captured wfid, so they track later writes.
- Issue notification:
  - issue_salu_wr_*_en are registered copies of salu_wr_*_en; issue_salu_wr_vcc_wfid is the registered salu_wr_wfid.
  - issue_valu_wr_vcc_en / issue_valu_wr_vcc_wfid are the registered accepted VALU write and its wfid. Both are 0 when no VALU write is accepted.

## Timing
- Reset clears all storage, captured wfids and issue outputs to 0, so every output reads 0 after reset.
- Reset wins over any simultaneous write or read request.
- Write latency: data is committed at the edge where the enable is sampled, and is visible on read outputs from that edge onward when the wfid is already captured.
- Read latency: the enable and wfid are sampled at edge N; outputs show the entry from edge N (including any write committed at edge N).
- Issue notifications are 1-cycle pulses following the write cycle, one per write cycle.
- Read and write to the same wfid in one cycle: the read output shows the new value.

## Test plan
- Reset: assert rst for 1 cycle -> all outputs 0; issue_* = 0.
- Init/read: fetch init wf2 with value 0x2D, then simd0_rd_en with wfid 2 and lsu_rd_wfid 2 -> next cycle simd_rd_exec_value = lsu_exec_value = 0x2D; simd_rd_vcc_value, simd_rd_m0_value and simd_rd_scc_value = 0. Then simf2_rd_en with wfid 2 -> simf_rd_exec_value = 0x2D.
- SALU write wf2 (exec 0x09, vcc 0x1B, scc 1, m0 0x0D) -> next cycle all four issue_salu_wr_*_en = 1 for one cycle, issue_salu_wr_vcc_wfid = 2; simf_rd_exec_value becomes 0x09, simf_rd_vcc_value 0x1B.
- VALU grant: rfa_select_fu = 2, simd1 VCC write of 0x05 to wf2 -> issue_valu_wr_vcc_en = 1 with wfid 2 for one cycle. Repeat with rfa_select_fu = 0 -> write ignored, no notification.
- SALU read wf2 after the above -> salu_rd_exec_value = 0x09, salu_rd_vcc_value = 0x05, salu_rd_m0_value = 0x0D, salu_rd_scc_value = 1.
- Collision: same-cycle SALU VCC 0xAA and granted simd0 VCC 0xBB to wf3 -> VCC(3) = 0xAA; fetch init to wf3 in the same cycle as an SALU exec write -> EXEC(3) = init value.

Source files
------------

// File: rtl/exec_unit.sv
// Per-wavefront scalar state (EXEC, VCC, M0, SCC) with held-wfid read ports for the
// SALU, SIMD, SIMF and LSU, and one-cycle write-done notifications back to issue.
module exec_unit #(
  parameter int NUMWF = 40
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        fetch_init_wf_en,
  input  logic [5:0]  fetch_init_wf_id,
  input  logic [63:0] fetch_init_value,

  input  logic        salu_wr_exec_en,
  input  logic        salu_wr_vcc_en,
  input  logic        salu_wr_m0_en,
  input  logic        salu_wr_scc_en,
  input  logic [5:0]  salu_wr_wfid,
  input  logic [63:0] salu_wr_exec_value,
  input  logic [63:0] salu_wr_vcc_value,
  input  logic [31:0] salu_wr_m0_value,
  input  logic        salu_wr_scc_value,

  input  logic        salu_rd_en,
  input  logic [5:0]  salu_rd_wfid,

  input  logic        simd0_rd_en,
  input  logic [5:0]  simd0_rd_wfid,
  input  logic        simd1_rd_en,
  input  logic [5:0]  simd1_rd_wfid,
  input  logic        simd2_rd_en,
  input  logic [5:0]  simd2_rd_wfid,
  input  logic        simd3_rd_en,
  input  logic [5:0]  simd3_rd_wfid,

  input  logic        simf0_rd_en,
  input  logic [5:0]  simf0_rd_wfid,
  input  logic        simf1_rd_en,
  input  logic [5:0]  simf1_rd_wfid,
  input  logic        simf2_rd_en,
  input  logic [5:0]  simf2_rd_wfid,
  input  logic        simf3_rd_en,
  input  logic [5:0]  simf3_rd_wfid,

  input  logic        simd0_vcc_wr_en,
  input  logic [5:0]  simd0_vcc_wr_wfid,
  input  logic [63:0] simd0_vcc_value,
  input  logic        simd1_vcc_wr_en,
  input  logic [5:0]  simd1_vcc_wr_wfid,
  input  logic [63:0] simd1_vcc_value,
  input  logic        simd2_vcc_wr_en,
  input  logic [5:0]  simd2_vcc_wr_wfid,
  input  logic [63:0] simd2_vcc_value,
  input  logic        simd3_vcc_wr_en,
  input  logic [5:0]  simd3_vcc_wr_wfid,
  input  logic [63:0] simd3_vcc_value,

  input  logic        simf0_vcc_wr_en,
  input  logic [5:0]  simf0_vcc_wr_wfid,
  input  logic [63:0] simf0_vcc_value,
  input  logic        simf1_vcc_wr_en,
  input  logic [5:0]  simf1_vcc_wr_wfid,
  input  logic [63:0] simf1_vcc_value,
  input  logic        simf2_vcc_wr_en,
  input  logic [5:0]  simf2_vcc_wr_wfid,
  input  logic [63:0] simf2_vcc_value,
  input  logic        simf3_vcc_wr_en,
  input  logic [5:0]  simf3_vcc_wr_wfid,
  input  logic [63:0] simf3_vcc_value,

  input  logic [15:0] rfa_select_fu,
  input  logic [5:0]  lsu_rd_wfid,

  output logic [63:0] lsu_exec_value,
  output logic [31:0] lsu_rd_m0_value,

  output logic [63:0] salu_rd_exec_value,
  output logic [63:0] salu_rd_vcc_value,
  output logic [31:0] salu_rd_m0_value,
  output logic        salu_rd_scc_value,

  output logic [63:0] simd_rd_exec_value,
  output logic [63:0] simd_rd_vcc_value,
  output logic [31:0] simd_rd_m0_value,
  output logic        simd_rd_scc_value,

  output logic [63:0] simf_rd_exec_value,
  output logic [63:0] simf_rd_vcc_value,
  output logic [31:0] simf_rd_m0_value,
  output logic        simf_rd_scc_value,

  output logic        issue_salu_wr_exec_en,
  output logic        issue_salu_wr_vcc_en,
  output logic        issue_salu_wr_m0_en,
  output logic        issue_salu_wr_scc_en,
  output logic [5:0]  issue_salu_wr_vcc_wfid,
  output logic        issue_valu_wr_vcc_en,
  output logic [5:0]  issue_valu_wr_vcc_wfid
);

  localparam int NVALU   = 8;
  localparam int NRD     = 4;
  localparam int RD_SALU = 0;
  localparam int RD_SIMD = 1;
  localparam int RD_SIMF = 2;
  localparam int RD_LSU  = 3;

  logic [63:0]      exec_reg [NUMWF];
  logic [63:0]      vcc_reg  [NUMWF];
  logic [31:0]      m0_reg   [NUMWF];
  logic [NUMWF-1:0] scc_reg;

  // ---------------- VALU VCC write arbitration ----------------
  logic [NVALU-1:0] valu_req;
  logic [5:0]       valu_wfid  [NVALU];
  logic [63:0]      valu_value [NVALU];
  logic             valu_sel_en;
  logic [5:0]       valu_sel_wfid;
  logic [63:0]      valu_sel_value;
  logic             unused_rfa_hi;

  assign unused_rfa_hi = ^rfa_select_fu[15:8];

  assign valu_req = {simf3_vcc_wr_en, simf2_vcc_wr_en, simf1_vcc_wr_en, simf0_vcc_wr_en,
                     simd3_vcc_wr_en, simd2_vcc_wr_en, simd1_vcc_wr_en, simd0_vcc_wr_en}
                    & rfa_select_fu[7:0];

  assign valu_wfid[0] = simd0_vcc_wr_wfid;  assign valu_value[0] = simd0_vcc_value;
  assign valu_wfid[1] = simd1_vcc_wr_wfid;  assign valu_value[1] = simd1_vcc_value;
  assign valu_wfid[2] = simd2_vcc_wr_wfid;  assign valu_value[2] = simd2_vcc_value;
  assign valu_wfid[3] = simd3_vcc_wr_wfid;  assign valu_value[3] = simd3_vcc_value;
  assign valu_wfid[4] = simf0_vcc_wr_wfid;  assign valu_value[4] = simf0_vcc_value;
  assign valu_wfid[5] = simf1_vcc_wr_wfid;  assign valu_value[5] = simf1_vcc_value;
  assign valu_wfid[6] = simf2_vcc_wr_wfid;  assign valu_value[6] = simf2_vcc_value;
  assign valu_wfid[7] = simf3_vcc_wr_wfid;  assign valu_value[7] = simf3_vcc_value;

  // Scan from the top down so the lowest qualifying unit is the last to overwrite.
  always_comb begin
    valu_sel_en    = 1'b0;
    valu_sel_wfid  = '0;
    valu_sel_value = '0;
    for (int k = NVALU - 1; k >= 0; k--) begin
      if (valu_req[k]) begin
        valu_sel_en    = 1'b1;
        valu_sel_wfid  = valu_wfid[k];
        valu_sel_value = valu_value[k];
      end
    end
  end

  // ---------------- Per-entry write decode ----------------
  logic [NUMWF-1:0] init_hit;
  logic [NUMWF-1:0] salu_hit;
  logic [NUMWF-1:0] valu_hit;

  for (genvar gi = 0; gi < NUMWF; gi++) begin : g_hit
    assign init_hit[gi] = fetch_init_wf_en && (fetch_init_wf_id == 6'(gi));
    assign salu_hit[gi] = (salu_wr_wfid == 6'(gi));
    assign valu_hit[gi] = valu_sel_en && (valu_sel_wfid == 6'(gi));
  end

  // Fetch init overrides every field; otherwise SALU beats VALU on VCC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMWF; i++) begin
        exec_reg[i] <= '0;
        vcc_reg[i]  <= '0;
        m0_reg[i]   <= '0;
      end
      scc_reg <= '0;
    end else begin
      for (int i = 0; i < NUMWF; i++) begin
        if (init_hit[i]) begin
          exec_reg[i] <= fetch_init_value;
          vcc_reg[i]  <= '0;
          m0_reg[i]   <= '0;
          scc_reg[i]  <= 1'b0;
        end else begin
          if (salu_hit[i] && salu_wr_exec_en)
            exec_reg[i] <= salu_wr_exec_value;
          if (salu_hit[i] && salu_wr_vcc_en)
            vcc_reg[i] <= salu_wr_vcc_value;
          else if (valu_hit[i])
            vcc_reg[i] <= valu_sel_value;
          if (salu_hit[i] && salu_wr_m0_en)
            m0_reg[i] <= salu_wr_m0_value;
          if (salu_hit[i] && salu_wr_scc_en)
            scc_reg[i] <= salu_wr_scc_value;
        end
      end
    end
  end

  // ---------------- Read ports ----------------
  function automatic logic [6:0] pick_lowest(input logic [3:0] en,
                                             input logic [5:0] w0, input logic [5:0] w1,
                                             input logic [5:0] w2, input logic [5:0] w3);
    logic [6:0] r;
    r = '0;
    if (en[3]) r = {1'b1, w3};
    if (en[2]) r = {1'b1, w2};
    if (en[1]) r = {1'b1, w1};
    if (en[0]) r = {1'b1, w0};
    return r;
  endfunction

  logic [6:0]     simd_pick;
  logic [6:0]     simf_pick;
  logic [NRD-1:0] rd_cap_en;
  logic [5:0]     rd_cap_wfid [NRD];
  logic [5:0]     rd_wfid_reg [NRD];
  logic [63:0]    rd_exec [NRD];
  logic [63:0]    rd_vcc  [NRD];
  logic [31:0]    rd_m0   [NRD];
  logic [NRD-1:0] rd_scc;

  assign simd_pick = pick_lowest({simd3_rd_en, simd2_rd_en, simd1_rd_en, simd0_rd_en},
                                 simd0_rd_wfid, simd1_rd_wfid, simd2_rd_wfid, simd3_rd_wfid);
  assign simf_pick = pick_lowest({simf3_rd_en, simf2_rd_en, simf1_rd_en, simf0_rd_en},
                                 simf0_rd_wfid, simf1_rd_wfid, simf2_rd_wfid, simf3_rd_wfid);

  assign rd_cap_en[RD_SALU]   = salu_rd_en;
  assign rd_cap_wfid[RD_SALU] = salu_rd_wfid;
  assign rd_cap_en[RD_SIMD]   = simd_pick[6];
  assign rd_cap_wfid[RD_SIMD] = simd_pick[5:0];
  assign rd_cap_en[RD_SIMF]   = simf_pick[6];
  assign rd_cap_wfid[RD_SIMF] = simf_pick[5:0];
  assign rd_cap_en[RD_LSU]    = 1'b1;
  assign rd_cap_wfid[RD_LSU]  = lsu_rd_wfid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NRD; k++) rd_wfid_reg[k] <= '0;
    end else begin
      for (int k = 0; k < NRD; k++)
        if (rd_cap_en[k]) rd_wfid_reg[k] <= rd_cap_wfid[k];
    end
  end

  // Reads look straight into storage so a write at the capture edge is already visible.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic       in_range;
    logic [5:0] idx;
    assign in_range    = (rd_wfid_reg[gi] < 6'(NUMWF));
    assign idx         = in_range ? rd_wfid_reg[gi] : 6'd0;
    assign rd_exec[gi] = in_range ? exec_reg[idx] : 64'd0;
    assign rd_vcc[gi]  = in_range ? vcc_reg[idx]  : 64'd0;
    assign rd_m0[gi]   = in_range ? m0_reg[idx]   : 32'd0;
    assign rd_scc[gi]  = in_range ? scc_reg[idx]  : 1'b0;
  end

  assign salu_rd_exec_value = rd_exec[RD_SALU];
  assign salu_rd_vcc_value  = rd_vcc[RD_SALU];
  assign salu_rd_m0_value   = rd_m0[RD_SALU];
  assign salu_rd_scc_value  = rd_scc[RD_SALU];

  assign simd_rd_exec_value = rd_exec[RD_SIMD];
  assign simd_rd_vcc_value  = rd_vcc[RD_SIMD];
  assign simd_rd_m0_value   = rd_m0[RD_SIMD];
  assign simd_rd_scc_value  = rd_scc[RD_SIMD];

  assign simf_rd_exec_value = rd_exec[RD_SIMF];
  assign simf_rd_vcc_value  = rd_vcc[RD_SIMF];
  assign simf_rd_m0_value   = rd_m0[RD_SIMF];
  assign simf_rd_scc_value  = rd_scc[RD_SIMF];

  assign lsu_exec_value  = rd_exec[RD_LSU];
  assign lsu_rd_m0_value = rd_m0[RD_LSU];

  // ---------------- Issue notifications ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_salu_wr_exec_en  <= 1'b0;
      issue_salu_wr_vcc_en   <= 1'b0;
      issue_salu_wr_m0_en    <= 1'b0;
      issue_salu_wr_scc_en   <= 1'b0;
      issue_salu_wr_vcc_wfid <= '0;
      issue_valu_wr_vcc_en   <= 1'b0;
      issue_valu_wr_vcc_wfid <= '0;
    end else begin
      issue_salu_wr_exec_en  <= salu_wr_exec_en;
      issue_salu_wr_vcc_en   <= salu_wr_vcc_en;
      issue_salu_wr_m0_en    <= salu_wr_m0_en;
      issue_salu_wr_scc_en   <= salu_wr_scc_en;
      issue_salu_wr_vcc_wfid <= salu_wr_wfid;
      issue_valu_wr_vcc_en   <= valu_sel_en;
      issue_valu_wr_vcc_wfid <= valu_sel_wfid;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus queues expected read values and issue pulses,
// a negedge monitor pops and compares them when they come due or when issue pulses appear.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fetch_init_wf_en;   logic [5:0] fetch_init_wf_id;  logic [63:0] fetch_init_value;
  logic        salu_wr_exec_en, salu_wr_vcc_en, salu_wr_m0_en, salu_wr_scc_en;
  logic [5:0]  salu_wr_wfid;
  logic [63:0] salu_wr_exec_value, salu_wr_vcc_value;
  logic [31:0] salu_wr_m0_value;
  logic        salu_wr_scc_value;
  logic        salu_rd_en;         logic [5:0] salu_rd_wfid;
  logic [3:0]  simd_rd_en, simf_rd_en;
  logic [5:0]  simd_rd_wfid [4];
  logic [5:0]  simf_rd_wfid [4];
  logic [3:0]  simd_wr_en, simf_wr_en;
  logic [5:0]  simd_wr_wfid [4];
  logic [5:0]  simf_wr_wfid [4];
  logic [63:0] simd_wr_val [4];
  logic [63:0] simf_wr_val [4];
  logic [15:0] rfa_select_fu;
  logic [5:0]  lsu_rd_wfid;

  logic [63:0] lsu_exec_value;     logic [31:0] lsu_rd_m0_value;
  logic [63:0] salu_rd_exec_value, salu_rd_vcc_value; logic [31:0] salu_rd_m0_value; logic salu_rd_scc_value;
  logic [63:0] simd_rd_exec_value, simd_rd_vcc_value; logic [31:0] simd_rd_m0_value; logic simd_rd_scc_value;
  logic [63:0] simf_rd_exec_value, simf_rd_vcc_value; logic [31:0] simf_rd_m0_value; logic simf_rd_scc_value;
  logic        issue_salu_wr_exec_en, issue_salu_wr_vcc_en, issue_salu_wr_m0_en, issue_salu_wr_scc_en;
  logic [5:0]  issue_salu_wr_vcc_wfid;
  logic        issue_valu_wr_vcc_en;
  logic [5:0]  issue_valu_wr_vcc_wfid;

  exec_unit #(.NUMWF(40)) dut (
    .clk(clk), .rst(rst),
    .fetch_init_wf_en(fetch_init_wf_en), .fetch_init_wf_id(fetch_init_wf_id), .fetch_init_value(fetch_init_value),
    .salu_wr_exec_en(salu_wr_exec_en), .salu_wr_vcc_en(salu_wr_vcc_en),
    .salu_wr_m0_en(salu_wr_m0_en), .salu_wr_scc_en(salu_wr_scc_en), .salu_wr_wfid(salu_wr_wfid),
    .salu_wr_exec_value(salu_wr_exec_value), .salu_wr_vcc_value(salu_wr_vcc_value),
    .salu_wr_m0_value(salu_wr_m0_value), .salu_wr_scc_value(salu_wr_scc_value),
    .salu_rd_en(salu_rd_en), .salu_rd_wfid(salu_rd_wfid),
    .simd0_rd_en(simd_rd_en[0]), .simd0_rd_wfid(simd_rd_wfid[0]),
    .simd1_rd_en(simd_rd_en[1]), .simd1_rd_wfid(simd_rd_wfid[1]),
    .simd2_rd_en(simd_rd_en[2]), .simd2_rd_wfid(simd_rd_wfid[2]),
    .simd3_rd_en(simd_rd_en[3]), .simd3_rd_wfid(simd_rd_wfid[3]),
    .simf0_rd_en(simf_rd_en[0]), .simf0_rd_wfid(simf_rd_wfid[0]),
    .simf1_rd_en(simf_rd_en[1]), .simf1_rd_wfid(simf_rd_wfid[1]),
    .simf2_rd_en(simf_rd_en[2]), .simf2_rd_wfid(simf_rd_wfid[2]),
    .simf3_rd_en(simf_rd_en[3]), .simf3_rd_wfid(simf_rd_wfid[3]),
    .simd0_vcc_wr_en(simd_wr_en[0]), .simd0_vcc_wr_wfid(simd_wr_wfid[0]), .simd0_vcc_value(simd_wr_val[0]),
    .simd1_vcc_wr_en(simd_wr_en[1]), .simd1_vcc_wr_wfid(simd_wr_wfid[1]), .simd1_vcc_value(simd_wr_val[1]),
    .simd2_vcc_wr_en(simd_wr_en[2]), .simd2_vcc_wr_wfid(simd_wr_wfid[2]), .simd2_vcc_value(simd_wr_val[2]),
    .simd3_vcc_wr_en(simd_wr_en[3]), .simd3_vcc_wr_wfid(simd_wr_wfid[3]), .simd3_vcc_value(simd_wr_val[3]),
    .simf0_vcc_wr_en(simf_wr_en[0]), .simf0_vcc_wr_wfid(simf_wr_wfid[0]), .simf0_vcc_value(simf_wr_val[0]),
    .simf1_vcc_wr_en(simf_wr_en[1]), .simf1_vcc_wr_wfid(simf_wr_wfid[1]), .simf1_vcc_value(simf_wr_val[1]),
    .simf2_vcc_wr_en(simf_wr_en[2]), .simf2_vcc_wr_wfid(simf_wr_wfid[2]), .simf2_vcc_value(simf_wr_val[2]),
    .simf3_vcc_wr_en(simf_wr_en[3]), .simf3_vcc_wr_wfid(simf_wr_wfid[3]), .simf3_vcc_value(simf_wr_val[3]),
    .rfa_select_fu(rfa_select_fu), .lsu_rd_wfid(lsu_rd_wfid),
    .lsu_exec_value(lsu_exec_value), .lsu_rd_m0_value(lsu_rd_m0_value),
    .salu_rd_exec_value(salu_rd_exec_value), .salu_rd_vcc_value(salu_rd_vcc_value),
    .salu_rd_m0_value(salu_rd_m0_value), .salu_rd_scc_value(salu_rd_scc_value),
    .simd_rd_exec_value(simd_rd_exec_value), .simd_rd_vcc_value(simd_rd_vcc_value),
    .simd_rd_m0_value(simd_rd_m0_value), .simd_rd_scc_value(simd_rd_scc_value),
    .simf_rd_exec_value(simf_rd_exec_value), .simf_rd_vcc_value(simf_rd_vcc_value),
    .simf_rd_m0_value(simf_rd_m0_value), .simf_rd_scc_value(simf_rd_scc_value),
    .issue_salu_wr_exec_en(issue_salu_wr_exec_en), .issue_salu_wr_vcc_en(issue_salu_wr_vcc_en),
    .issue_salu_wr_m0_en(issue_salu_wr_m0_en), .issue_salu_wr_scc_en(issue_salu_wr_scc_en),
    .issue_salu_wr_vcc_wfid(issue_salu_wr_vcc_wfid),
    .issue_valu_wr_vcc_en(issue_valu_wr_vcc_en), .issue_valu_wr_vcc_wfid(issue_valu_wr_vcc_wfid)
  );

  localparam int S_SALU_EXEC = 0, S_SALU_VCC = 1, S_SALU_M0 = 2, S_SALU_SCC = 3;
  localparam int S_SIMD_EXEC = 4, S_SIMD_VCC = 5, S_SIMD_M0 = 6, S_SIMD_SCC = 7;
  localparam int S_SIMF_EXEC = 8, S_SIMF_VCC = 9, S_SIMF_M0 = 10, S_SIMF_SCC = 11;
  localparam int S_LSU_EXEC = 12, S_LSU_M0 = 13;

  typedef struct { int due; int sig; logic [63:0] val; string name; } rd_exp_t;
  typedef struct { int due; logic [3:0] salu_en; logic [5:0] salu_wfid;
                   logic valu_en; logic [5:0] valu_wfid; } iss_exp_t;

  rd_exp_t  rd_q[$];
  iss_exp_t iss_q[$];
  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sig_val(input int id);
    case (id)
      S_SALU_EXEC: return salu_rd_exec_value;
      S_SALU_VCC:  return salu_rd_vcc_value;
      S_SALU_M0:   return {32'd0, salu_rd_m0_value};
      S_SALU_SCC:  return {63'd0, salu_rd_scc_value};
      S_SIMD_EXEC: return simd_rd_exec_value;
      S_SIMD_VCC:  return simd_rd_vcc_value;
      S_SIMD_M0:   return {32'd0, simd_rd_m0_value};
      S_SIMD_SCC:  return {63'd0, simd_rd_scc_value};
      S_SIMF_EXEC: return simf_rd_exec_value;
      S_SIMF_VCC:  return simf_rd_vcc_value;
      S_SIMF_M0:   return {32'd0, simf_rd_m0_value};
      S_SIMF_SCC:  return {63'd0, simf_rd_scc_value};
      S_LSU_EXEC:  return lsu_exec_value;
      default:     return {32'd0, lsu_rd_m0_value};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Monitor: read values compared when due; issue pulses compared when present or due.
  always @(negedge clk) begin
    rd_exp_t  r;
    iss_exp_t e;
    logic [3:0] salu_en;
    if (mon_on) begin
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        check(r.name, sig_val(r.sig), r.val);
      end
      salu_en = {issue_salu_wr_scc_en, issue_salu_wr_m0_en, issue_salu_wr_vcc_en, issue_salu_wr_exec_en};
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        e = iss_q.pop_front();
        check("issue_salu_en", {60'd0, salu_en}, {60'd0, e.salu_en});
        if (e.salu_en != 4'd0)
          check("issue_salu_wfid", {58'd0, issue_salu_wr_vcc_wfid}, {58'd0, e.salu_wfid});
        check("issue_valu_en", {63'd0, issue_valu_wr_vcc_en}, {63'd0, e.valu_en});
        check("issue_valu_wfid", {58'd0, issue_valu_wr_vcc_wfid}, {58'd0, e.valu_wfid});
      end else if ((salu_en != 4'd0) || issue_valu_wr_vcc_en) begin
        chk_cnt++;
        $display("FAIL issue_stray: salu_en=%b valu_en=%b, expected no pulse (cycle %0d)",
                 salu_en, issue_valu_wr_vcc_en, cyc);
      end
    end
  end

  task automatic exp_rd(input int sig, input logic [63:0] v, input string n, input int lat = 1);
    rd_q.push_back('{cyc + lat, sig, v, n});
  endtask

  task automatic exp_iss(input logic [3:0] se, input logic [5:0] sw, input logic ve, input logic [5:0] vw);
    iss_q.push_back('{cyc + 1, se, sw, ve, vw});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_init_wf_en = 0; fetch_init_wf_id = 0; fetch_init_value = 0;
    salu_wr_exec_en = 0; salu_wr_vcc_en = 0; salu_wr_m0_en = 0; salu_wr_scc_en = 0;
    salu_wr_wfid = 0; salu_wr_exec_value = 0; salu_wr_vcc_value = 0;
    salu_wr_m0_value = 0; salu_wr_scc_value = 0;
    salu_rd_en = 0; salu_rd_wfid = 0;
    simd_rd_en = 0; simf_rd_en = 0; simd_wr_en = 0; simf_wr_en = 0;
    for (int k = 0; k < 4; k++) begin
      simd_rd_wfid[k] = 0; simf_rd_wfid[k] = 0;
      simd_wr_wfid[k] = 0; simf_wr_wfid[k] = 0;
      simd_wr_val[k] = 0;  simf_wr_val[k] = 0;
    end
    rfa_select_fu = 0;
  endtask

  initial begin
    clear_inputs();
    lsu_rd_wfid = 0;
    rst = 1;
    // Requests during reset must be ignored.
    fetch_init_wf_en = 1; fetch_init_wf_id = 0; fetch_init_value = 64'h1111;
    salu_wr_scc_en = 1; salu_wr_scc_value = 1; salu_rd_en = 1; salu_rd_wfid = 0;
    tick(); tick();
    rst = 0;
    clear_inputs();
    mon_on = 1'b1;
    for (int s = 0; s <= S_LSU_M0; s++) exp_rd(s, 64'd0, $sformatf("reset_out%0d", s), 0);

    // Init wf2 with EXEC 0x2D.
    fetch_init_wf_en = 1; fetch_init_wf_id = 2; fetch_init_value = 64'h2D;
    tick(); clear_inputs();

    // SIMD0 and LSU read wf2.
    simd_rd_en[0] = 1; simd_rd_wfid[0] = 2; lsu_rd_wfid = 2;
    exp_rd(S_SIMD_EXEC, 64'h2D, "simd_exec_init");
    exp_rd(S_SIMD_VCC, 64'h0, "simd_vcc_init");
    exp_rd(S_SIMD_M0, 64'h0, "simd_m0_init");
    exp_rd(S_SIMD_SCC, 64'h0, "simd_scc_init");
    exp_rd(S_LSU_EXEC, 64'h2D, "lsu_exec_init");
    exp_rd(S_LSU_M0, 64'h0, "lsu_m0_init");
    tick(); clear_inputs();

    // SIMF2 (wf2) and SIMF3 (wf7) together: lowest index wins.
    simf_rd_en[2] = 1; simf_rd_wfid[2] = 2; simf_rd_en[3] = 1; simf_rd_wfid[3] = 7;
    exp_rd(S_SIMF_EXEC, 64'h2D, "simf_exec_init");
    tick(); clear_inputs();

    // SALU writes all four fields of wf2; SIMF already watches wf2.
    salu_wr_exec_en = 1; salu_wr_vcc_en = 1; salu_wr_m0_en = 1; salu_wr_scc_en = 1;
    salu_wr_wfid = 2; salu_wr_exec_value = 64'h09; salu_wr_vcc_value = 64'h1B;
    salu_wr_m0_value = 32'h0D; salu_wr_scc_value = 1;
    exp_iss(4'b1111, 6'd2, 1'b0, 6'd0);
    exp_rd(S_SIMF_EXEC, 64'h09, "simf_exec_salu");
    exp_rd(S_SIMF_VCC, 64'h1B, "simf_vcc_salu");
    exp_rd(S_SIMF_M0, 64'h0D, "simf_m0_salu");
    exp_rd(S_SIMF_SCC, 64'h1, "simf_scc_salu");
    exp_rd(S_LSU_EXEC, 64'h09, "lsu_exec_salu");
    tick(); clear_inputs();

    // Granted simd1 VCC write; ungranted simd0 write must be ignored.
    rfa_select_fu = 16'h0002;
    simd_wr_en[1] = 1; simd_wr_wfid[1] = 2; simd_wr_val[1] = 64'h05;
    simd_wr_en[0] = 1; simd_wr_wfid[0] = 2; simd_wr_val[0] = 64'h77;
    exp_iss(4'b0000, 6'd0, 1'b1, 6'd2);
    exp_rd(S_SIMF_VCC, 64'h05, "simf_vcc_valu");
    tick(); clear_inputs();

    // No grant: write ignored, no notification.
    rfa_select_fu = 16'h0000;
    simd_wr_en[1] = 1; simd_wr_wfid[1] = 2; simd_wr_val[1] = 64'h99;
    exp_rd(S_SIMF_VCC, 64'h05, "simf_vcc_nogrant");
    tick(); clear_inputs();

    // Upper grant bits are ignored.
    rfa_select_fu = 16'hFF00;
    simf_wr_en[0] = 1; simf_wr_wfid[0] = 2; simf_wr_val[0] = 64'h98;
    exp_rd(S_SIMF_VCC, 64'h05, "simf_vcc_highbits");
    tick(); clear_inputs();

    // SALU read of wf2.
    salu_rd_en = 1; salu_rd_wfid = 2;
    exp_rd(S_SALU_EXEC, 64'h09, "salu_exec_rd");
    exp_rd(S_SALU_VCC, 64'h05, "salu_vcc_rd");
    exp_rd(S_SALU_M0, 64'h0D, "salu_m0_rd");
    exp_rd(S_SALU_SCC, 64'h1, "salu_scc_rd");
    tick(); clear_inputs();

    // SALU VCC beats granted simd0 VCC on wf3; same-cycle read sees the new value.
    salu_wr_vcc_en = 1; salu_wr_wfid = 3; salu_wr_vcc_value = 64'hAA;
    rfa_select_fu = 16'h0001;
    simd_wr_en[0] = 1; simd_wr_wfid[0] = 3; simd_wr_val[0] = 64'hBB;
    salu_rd_en = 1; salu_rd_wfid = 3;
    exp_iss(4'b0010, 6'd3, 1'b1, 6'd3);
    exp_rd(S_SALU_VCC, 64'hAA, "collide_vcc");
    tick(); clear_inputs();

    // Fetch init beats SALU exec on wf3 and clears VCC.
    fetch_init_wf_en = 1; fetch_init_wf_id = 3; fetch_init_value = 64'h1234;
    salu_wr_exec_en = 1; salu_wr_wfid = 3; salu_wr_exec_value = 64'h5555;
    exp_iss(4'b0001, 6'd3, 1'b0, 6'd0);
    exp_rd(S_SALU_EXEC, 64'h1234, "collide_exec");
    exp_rd(S_SALU_VCC, 64'h0, "init_clears_vcc");
    tick(); clear_inputs();

    // simf0 and simf1 both granted: simf0 (wf4) wins, wf5 untouched.
    rfa_select_fu = 16'h0030;
    simf_wr_en[0] = 1; simf_wr_wfid[0] = 4; simf_wr_val[0] = 64'h11;
    simf_wr_en[1] = 1; simf_wr_wfid[1] = 5; simf_wr_val[1] = 64'h22;
    exp_iss(4'b0000, 6'd0, 1'b1, 6'd4);
    tick(); clear_inputs();

    simd_rd_en[0] = 1; simd_rd_wfid[0] = 4; simf_rd_en[0] = 1; simf_rd_wfid[0] = 5;
    exp_rd(S_SIMD_VCC, 64'h11, "valu_lowest_wins");
    exp_rd(S_SIMF_VCC, 64'h0, "valu_loser_dropped");
    tick(); clear_inputs();

    // Boundary wfids: 39 stored, 45 dropped and reads back 0.
    fetch_init_wf_en = 1; fetch_init_wf_id = 39; fetch_init_value = 64'hCAFE;
    tick(); clear_inputs();
    fetch_init_wf_en = 1; fetch_init_wf_id = 45; fetch_init_value = 64'hFFFF;
    tick(); clear_inputs();
    salu_rd_en = 1; salu_rd_wfid = 45; lsu_rd_wfid = 39;
    exp_rd(S_SALU_EXEC, 64'h0, "oor_exec");
    exp_rd(S_LSU_EXEC, 64'hCAFE, "wf39_exec");
    exp_rd(S_LSU_M0, 64'h0, "wf39_m0");
    tick(); clear_inputs();

    // Held SIMD wfid (4) tracks a later SALU write.
    salu_wr_vcc_en = 1; salu_wr_wfid = 4; salu_wr_vcc_value = 64'h33;
    exp_iss(4'b0010, 6'd4, 1'b0, 6'd0);
    exp_rd(S_SIMD_VCC, 64'h33, "held_tracks_write");
    exp_rd(S_SIMD_EXEC, 64'h0, "held_exec");
    tick(); clear_inputs();

    tick(); tick(); tick();
    check("queues_drained", 64'(rd_q.size() + iss_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
